// File: rtl/bthowen_pkg.sv
// Shared types for the hash / Bloom-filter datapath: default hash width,
// the hash type and the filter-table contents vector.
package bthowen_pkg;

    localparam int DEF_HASH_WIDTH = 8;

    typedef logic [DEF_HASH_WIDTH-1:0]      hash_t;
    typedef logic [2**DEF_HASH_WIDTH-1:0]   tbl_bits_t;

    // Position of a table read within its query group, carried alongside the read
    typedef struct packed {
        logic first;
        logic last;
    } grp_flags_t;

endpackage

// File: rtl/bloom_table.sv
// 2^HASH_WIDTH x 1 filter table: one registered read port, one synchronous
// write port, reset reloads INIT_CONTENTS. Read-before-write on collisions.
module bloom_table import bthowen_pkg::*; #(
    parameter int                       HASH_WIDTH    = DEF_HASH_WIDTH,
    parameter logic [2**HASH_WIDTH-1:0] INIT_CONTENTS = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [HASH_WIDTH-1:0] rd_addr,
    output logic                  rd_data,
    input  logic                  wr_en,
    input  logic [HASH_WIDTH-1:0] wr_addr,
    input  logic                  wr_data
);

    logic [2**HASH_WIDTH-1:0] tbl;

    // Registered read and write share one edge; the read sees the old contents
    always_ff @(posedge clk) begin
        if (!rst) begin
            tbl     <= INIT_CONTENTS;
            rd_data <= 1'b0;
        end else begin
            rd_data <= tbl[rd_addr];
            if (wr_en)
                tbl[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/bloom_lookup.sv
// Bloom-filter membership query: one query per NUM_HASHES consecutive hashes,
// response = AND of the addressed table bits. Two-stage pipeline:
// stage 1 = table read, stage 2 = accumulate / emit.
module bloom_lookup import bthowen_pkg::*; #(
    parameter int                       HASH_WIDTH    = DEF_HASH_WIDTH,
    parameter int                       NUM_HASHES    = 2,
    parameter logic [2**HASH_WIDTH-1:0] INIT_CONTENTS = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inp_vld,
    input  logic [HASH_WIDTH-1:0] hash_in,
    input  logic                  prog_en,
    input  logic [HASH_WIDTH-1:0] prog_addr,
    input  logic                  prog_data,
    output logic                  outp_vld,
    output logic                  response
);

    localparam int                STAGES   = 2;
    localparam int                IDX_W    = (NUM_HASHES > 1) ? $clog2(NUM_HASHES) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_HASHES - 1);

    logic [IDX_W-1:0]  idx;
    logic [STAGES-1:0] vld_pipe;   // [0]: stage-1 read valid, [1]: response pulse
    grp_flags_t        s1_flags;
    logic              tbl_bit;
    logic              acc;
    logic              acc_next;

    bloom_table #(
        .HASH_WIDTH    (HASH_WIDTH),
        .INIT_CONTENTS (INIT_CONTENTS)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (hash_in),
        .rd_data (tbl_bit),
        .wr_en   (prog_en),
        .wr_addr (prog_addr),
        .wr_data (prog_data)
    );

    // A first entry restarts the running AND; otherwise fold the new bit in
    assign acc_next = s1_flags.first ? tbl_bit : (acc & tbl_bit);

    // Group counter and stage-1 flag capture alongside the table read
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx         <= '0;
            vld_pipe[0] <= 1'b0;
            s1_flags    <= '0;
        end else begin
            vld_pipe[0]    <= inp_vld;
            s1_flags.first <= (idx == '0);
            s1_flags.last  <= (idx == IDX_LAST);
            if (inp_vld)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // Stage 2: accumulate valid reads and pulse the response on the group's last hash
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc         <= 1'b0;
            vld_pipe[1] <= 1'b0;
            response    <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0] & s1_flags.last;
            if (vld_pipe[0]) begin
                acc <= acc_next;
                if (s1_flags.last)
                    response <= acc_next;
            end
        end
    end

    assign outp_vld = vld_pipe[1];

endmodule

// File: tb/tb_bloom_lookup.sv
// Bench for bloom_lookup: directed scenarios followed by a randomized stream,
// all compared cycle by cycle against a group-level reference model.
module tb_bloom_lookup;

    localparam int           HW   = 8;
    localparam int           NH   = 2;
    localparam int           DEPTH = 2**HW;
    localparam int           MAXC = 4096;
    localparam logic [DEPTH-1:0] INIT = (256'd1 << 5) | (256'd1 << 200);

    logic          clk = 1'b0;
    logic          rst;
    logic          inp_vld;
    logic [HW-1:0] hash_in;
    logic          prog_en;
    logic [HW-1:0] prog_addr;
    logic          prog_data;
    logic          outp_vld;
    logic          response;

    bloom_lookup #(
        .HASH_WIDTH    (HW),
        .NUM_HASHES    (NH),
        .INIT_CONTENTS (INIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .inp_vld   (inp_vld),
        .hash_in   (hash_in),
        .prog_en   (prog_en),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .outp_vld  (outp_vld),
        .response  (response)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: filter contents, the current partial group and a
    // per-cycle schedule of expected pulses / reset-cleared cycles.
    bit mtbl    [DEPTH];
    int grp_cnt = 0;
    bit grp_and = 1'b1;
    bit rsp_hold = 1'b0;
    bit exp_vld [MAXC];
    bit exp_rsp [MAXC];
    bit exp_rst [MAXC];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Apply one cycle of stimulus and advance the model by what it implies
    task automatic drive(input bit r, input bit iv, input int h, input bit pe, input int pa, input bit pd);
        rst       = r;
        inp_vld   = iv;
        hash_in   = h[HW-1:0];
        prog_en   = pe;
        prog_addr = pa[HW-1:0];
        prog_data = pd;
        if (!r) begin
            exp_rst[cyc+1] = 1'b1;
            exp_vld[cyc+1] = 1'b0;
            grp_cnt = 0;
            grp_and = 1'b1;
            for (int i = 0; i < DEPTH; i++) mtbl[i] = INIT[i];
        end else begin
            if (iv) begin
                grp_and = grp_and & mtbl[h];
                grp_cnt++;
                if (grp_cnt == NH) begin
                    exp_vld[cyc+2] = 1'b1;
                    exp_rsp[cyc+2] = grp_and;
                    grp_cnt = 0;
                    grp_and = 1'b1;
                end
            end
            if (pe) mtbl[pa] = pd;
        end
    endtask

    task automatic check_cycle();
        if (exp_rst[cyc]) begin
            rsp_hold = 1'b0;
            chk("vld_in_reset", {31'd0, outp_vld}, 32'd0);
        end else begin
            if (exp_vld[cyc]) rsp_hold = exp_rsp[cyc];
            chk("outp_vld", {31'd0, outp_vld}, {31'd0, exp_vld[cyc]});
        end
        chk("response", {31'd0, response}, {31'd0, rsp_hold});
    endtask

    task automatic tick(input bit r, input bit iv, input int h,
                        input bit pe = 1'b0, input int pa = 0, input bit pd = 1'b0);
        drive(r, iv, h, pe, pa, pd);
        @(negedge clk);
        cyc++;
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 0);
    endtask

    function automatic int pick_hash();
        case ($urandom_range(0, 4))
            0:       return 5;
            1:       return 200;
            2:       return 6;
            3:       return 7;
            default: return int'($urandom_range(0, DEPTH-1));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            exp_vld[i] = 1'b0;
            exp_rsp[i] = 1'b0;
            exp_rst[i] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) mtbl[i] = INIT[i];

        // Reset held for two cycles
        tick(1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 0);

        // 5,200 -> hit
        tick(1'b1, 1'b1, 5);
        tick(1'b1, 1'b1, 200);
        idle(3);

        // 5,6 -> miss
        tick(1'b1, 1'b1, 5);
        tick(1'b1, 1'b1, 6);
        idle(3);

        // Back-to-back groups: 1, 0, 1
        tick(1'b1, 1'b1, 5);
        tick(1'b1, 1'b1, 200);
        tick(1'b1, 1'b1, 200);
        tick(1'b1, 1'b1, 7);
        tick(1'b1, 1'b1, 5);
        tick(1'b1, 1'b1, 5);
        idle(3);

        // Gap inside a group
        tick(1'b1, 1'b1, 5);
        idle(3);
        tick(1'b1, 1'b1, 200);
        idle(3);

        // Same-cycle write/read of entry 6: old value first, new value next group
        tick(1'b1, 1'b1, 6, 1'b1, 6, 1'b1);
        tick(1'b1, 1'b1, 5);
        tick(1'b1, 1'b1, 6);
        tick(1'b1, 1'b1, 5);
        idle(3);

        // Clear entry 200, start a group, reset mid-group, then 200,5 must hit
        tick(1'b1, 1'b0, 0, 1'b1, 200, 1'b0);
        tick(1'b1, 1'b1, 5);
        tick(1'b0, 1'b1, 7, 1'b1, 5, 1'b0);
        tick(1'b1, 1'b1, 200);
        tick(1'b1, 1'b1, 5);
        idle(3);

        // Randomized stream with occasional writes and resets
        for (int n = 0; n < 1500; n++) begin
            bit r, iv, pe, pd;
            int h, pa;
            r  = ($urandom_range(0, 99) != 0);
            iv = ($urandom_range(0, 99) < 65);
            h  = pick_hash();
            pe = ($urandom_range(0, 7) == 0);
            pa = pick_hash();
            pd = 1'($urandom_range(0, 1));
            tick(r, iv, h, pe, pa, pd);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
